// File: rtl/dec10b8b_pkg.sv
// Shared definitions for the multi-lane 10b->8b stream decoder: symbol classes,
// control byte values, lock states and the half-symbol index tables.
package dec10b8b_pkg;

    localparam logic [2:0] CLS_ERR = 3'd0;
    localparam logic [2:0] CLS_32  = 3'd1;
    localparam logic [2:0] CLS_23  = 3'd2;
    localparam logic [2:0] CLS_41  = 3'd3;
    localparam logic [2:0] CLS_14  = 3'd4;

    localparam logic [7:0] K_NODATA = 8'h00;
    localparam logic [7:0] K_COMMA  = 8'h01;

    typedef enum logic {HUNT, LOCKED} lock_state_e;

    function automatic logic [2:0] pop5(input logic [4:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]} + {2'b00, v[4]};
    endfunction

    // Class is set by the (upper, lower) weight split; anything else is illegal.
    function automatic logic [2:0] sym_class(input logic [4:0] u, input logic [4:0] l);
        case ({pop5(u), pop5(l)})
            {3'd3, 3'd2}: return CLS_32;
            {3'd2, 3'd3}: return CLS_23;
            {3'd4, 3'd1}: return CLS_41;
            {3'd1, 3'd4}: return CLS_14;
            default:      return CLS_ERR;
        endcase
    endfunction

    function automatic logic [3:0] h3_idx(input logic [4:0] v);
        case (v)
            5'b00111: return 4'd0;
            5'b01011: return 4'd1;
            5'b01101: return 4'd2;
            5'b01110: return 4'd3;
            5'b10011: return 4'd4;
            5'b10101: return 4'd5;
            5'b10110: return 4'd6;
            5'b11001: return 4'd7;
            5'b11010: return 4'd8;
            5'b11100: return 4'd9;
            default:  return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] h2_idx(input logic [4:0] v);
        case (v)
            5'b00011: return 4'd0;
            5'b00101: return 4'd1;
            5'b00110: return 4'd2;
            5'b01010: return 4'd3;
            5'b01100: return 4'd4;
            5'b01001: return 4'd5;
            5'b10001: return 4'd6;
            5'b10010: return 4'd7;
            5'b10100: return 4'd8;
            5'b11000: return 4'd9;
            default:  return 4'd0;
        endcase
    endfunction

    function automatic logic [2:0] h4_idx(input logic [4:0] v);
        case (v)
            5'b11110: return 3'd0;
            5'b11101: return 3'd1;
            5'b11011: return 3'd2;
            5'b10111: return 3'd3;
            5'b01111: return 3'd4;
            default:  return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] h1_idx(input logic [4:0] v);
        case (v)
            5'b00001: return 3'd0;
            5'b00010: return 3'd1;
            5'b00100: return 3'd2;
            5'b01000: return 3'd3;
            5'b10000: return 3'd4;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dec10b8b_stream_sym_dec.sv
// Combinational single-lane 10b->8b decode: one symbol in, byte + K + error out.
module sym_dec_10b8b
    import dec10b8b_pkg::*;
(
    input  logic [9:0] sym_i,
    output logic [7:0] data_o,
    output logic       k_o,
    output logic       err_o
);

    logic [4:0] u, l;
    logic [3:0] a, b;

    assign u = sym_i[9:5];
    assign l = sym_i[4:0];

    always_comb begin
        data_o = 8'h00;
        k_o    = 1'b0;
        err_o  = 1'b0;
        a      = 4'd0;
        b      = 4'd0;
        case (sym_class(u, l))
            CLS_32: begin
                a = h3_idx(u);
                b = h2_idx(l);
                if (!a[3] && !b[3])  data_o = {2'b00, a[2:0], b[2:0]};
                else if (!b[3])      data_o = {4'b1000, a[0], b[2:0]};
                else if (!a[3])      data_o = {4'b1010, b[0], a[2:0]};
                else                 data_o = {6'b111100, a[0], b[0]};
            end
            CLS_23: begin
                a = h2_idx(u);
                b = h3_idx(l);
                if (!a[3] && !b[3])  data_o = {2'b01, a[2:0], b[2:0]};
                else if (!b[3])      data_o = {4'b1001, a[0], b[2:0]};
                else if (!a[3])      data_o = {4'b1011, b[0], a[2:0]};
                else if (a[0])       data_o = {6'b111101, 1'b0, b[0]};
                else begin
                    // a=8 with b in {8,9} is the control-symbol corner of the code space
                    k_o    = 1'b1;
                    data_o = b[0] ? K_COMMA : K_NODATA;
                end
            end
            CLS_41: begin
                a = {1'b0, h4_idx(u)};
                b = {1'b0, h1_idx(l)};
                if (!a[2] && !b[2])  data_o = {4'b1100, a[1:0], b[1:0]};
                else if (!b[2])      data_o = {6'b111000, b[1:0]};
                else if (!a[2])      data_o = {6'b111010, a[1:0]};
                else                 data_o = 8'hF6;
            end
            CLS_14: begin
                a = {1'b0, h1_idx(u)};
                b = {1'b0, h4_idx(l)};
                if (!a[2] && !b[2])  data_o = {4'b1101, a[1:0], b[1:0]};
                else if (!b[2])      data_o = {6'b111001, b[1:0]};
                else if (!a[2])      data_o = {6'b111011, a[1:0]};
                else                 data_o = 8'hF7;
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/dec10b8b_stream.sv
// Multi-lane 10b->8b stream decoder: per-lane decode, registered valid/ready
// output stage, link-lock FSM and saturating lane-error counter.
module dec10b8b_stream
    import dec10b8b_pkg::*;
#(
    parameter int LANES_P      = 2,
    parameter int LOCK_CNT_P   = 8,
    parameter int UNLOCK_CNT_P = 4,
    parameter int ERR_CNT_W_P  = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [10*LANES_P-1:0]    data_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [8*LANES_P-1:0]     data_o,
    output logic [LANES_P-1:0]       k_o,
    output logic [LANES_P-1:0]       err_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     locked_o,
    output logic [ERR_CNT_W_P-1:0]   err_cnt_o,
    input  logic                     err_clr_i
);

    localparam int CNT_MAX = (LOCK_CNT_P > UNLOCK_CNT_P) ? LOCK_CNT_P : UNLOCK_CNT_P;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CNT_P - 1);
    localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_CNT_P - 1);

    function automatic logic [ERR_CNT_W_P:0] popcnt(input logic [LANES_P-1:0] v);
        logic [ERR_CNT_W_P:0] n;
        n = '0;
        for (int i = 0; i < LANES_P; i++) n = n + (ERR_CNT_W_P+1)'(v[i]);
        return n;
    endfunction

    logic [LANES_P-1:0][7:0] dec_data;
    logic [LANES_P-1:0]      dec_k, dec_err;

    for (genvar g = 0; g < LANES_P; g++) begin : g_lane
        sym_dec_10b8b u_dec (
            .sym_i  (data_i[10*g +: 10]),
            .data_o (dec_data[g]),
            .k_o    (dec_k[g]),
            .err_o  (dec_err[g])
        );
    end

    logic                    valid_q, valid_d;
    logic [LANES_P-1:0][7:0] data_q, data_d;
    logic [LANES_P-1:0]      k_q, k_d, err_q, err_d;
    lock_state_e             state_q, state_d;
    logic [CNT_W-1:0]        run_q, run_d;
    logic [ERR_CNT_W_P-1:0]  err_cnt_q, err_cnt_d;
    logic [ERR_CNT_W_P:0]    err_sum;
    logic                    accept, beat_err;

    assign ready_o  = !valid_q || ready_i;
    assign accept   = valid_i && ready_o;
    assign beat_err = |dec_err;
    assign err_sum  = {1'b0, err_cnt_q} + popcnt(dec_err);

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        k_d     = k_q;
        err_d   = err_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = dec_data;
            k_d     = dec_k;
            err_d   = dec_err;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // run_q counts clean beats while hunting and errored beats while locked.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (accept) begin
            case (state_q)
                HUNT: begin
                    if (beat_err)                run_d = '0;
                    else if (run_q == LOCK_LAST) begin
                        state_d = LOCKED;
                        run_d   = '0;
                    end else                     run_d = run_q + 1'b1;
                end
                LOCKED: begin
                    if (!beat_err)                 run_d = '0;
                    else if (run_q == UNLOCK_LAST) begin
                        state_d = HUNT;
                        run_d   = '0;
                    end else                       run_d = run_q + 1'b1;
                end
                default: begin
                    state_d = HUNT;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr_i)    err_cnt_d = '0;
        else if (accept)  err_cnt_d = err_sum[ERR_CNT_W_P] ? '1 : err_sum[ERR_CNT_W_P-1:0];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            k_q       <= '0;
            err_q     <= '0;
            state_q   <= HUNT;
            run_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            k_q       <= k_d;
            err_q     <= err_d;
            state_q   <= state_d;
            run_q     <= run_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign k_o       = k_q;
    assign err_o     = err_q;
    assign locked_o  = (state_q == LOCKED);
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_dec10b8b_stream.sv
// Randomized self-checking bench for dec10b8b_stream against an arithmetic
// reference decoder and a cycle-level beat/lock/counter model.
module tb_dec10b8b_stream;

    localparam int LANES = 2;
    localparam int LOCKN = 8;
    localparam int UNLKN = 4;
    localparam int EW    = 4;
    localparam int EMAX  = (1 << EW) - 1;

    logic                 clk = 1'b0;
    logic                 reset_n_i = 1'b1;
    logic [10*LANES-1:0]  data_i = '0;
    logic                 valid_i = 1'b0;
    logic                 ready_o;
    logic [8*LANES-1:0]   data_o;
    logic [LANES-1:0]     k_o, err_o;
    logic                 valid_o;
    logic                 ready_i = 1'b0;
    logic                 locked_o;
    logic [EW-1:0]        err_cnt_o;
    logic                 err_clr_i = 1'b0;

    dec10b8b_stream #(
        .LANES_P(LANES), .LOCK_CNT_P(LOCKN), .UNLOCK_CNT_P(UNLKN), .ERR_CNT_W_P(EW)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .data_o(data_o), .k_o(k_o), .err_o(err_o),
        .valid_o(valid_o), .ready_i(ready_i), .locked_o(locked_o),
        .err_cnt_o(err_cnt_o), .err_clr_i(err_clr_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---- reference decoder straight from the code tables ----
    function automatic int rank3(input int u);
        int r = 0;
        for (int x = 0; x < u; x++) if ($countones(5'(x)) == 3) r++;
        return r;
    endfunction

    function automatic int idx2(input int v);
        int tab[10] = '{3, 5, 6, 10, 12, 9, 17, 18, 20, 24};
        for (int i = 0; i < 10; i++) if (tab[i] == v) return i;
        return -1;
    endfunction

    function automatic int bitpos(input int v, input int val);
        for (int i = 0; i < 5; i++) if (((v >> i) & 1) == val) return i;
        return -1;
    endfunction

    function automatic logic [9:0] ref_dec(input logic [9:0] s);
        int u, l, pu, pl, a, b, d;
        logic k, e;
        u = int'(s[9:5]); l = int'(s[4:0]);
        pu = $countones(s[9:5]); pl = $countones(s[4:0]);
        d = 0; k = 1'b0; e = 1'b0;
        if (pu == 3 && pl == 2) begin
            a = rank3(u); b = idx2(l);
            if (a < 8 && b < 8)  d = a * 8 + b;
            else if (b < 8)      d = 128 + (a % 2) * 8 + b;
            else if (a < 8)      d = 160 + (b % 2) * 8 + a;
            else                 d = 240 + (a % 2) * 2 + (b % 2);
        end else if (pu == 2 && pl == 3) begin
            a = idx2(u); b = rank3(l);
            if (a < 8 && b < 8)  d = 64 + a * 8 + b;
            else if (b < 8)      d = 144 + (a % 2) * 8 + b;
            else if (a < 8)      d = 176 + (b % 2) * 8 + a;
            else if (a == 9)     d = 244 + (b % 2);
            else begin k = 1'b1; d = b - 8; end
        end else if (pu == 4 && pl == 1) begin
            a = bitpos(u, 0); b = bitpos(l, 1);
            if (a < 4 && b < 4)  d = 192 + a * 4 + b;
            else if (b < 4)      d = 224 + b;
            else if (a < 4)      d = 232 + a;
            else                 d = 246;
        end else if (pu == 1 && pl == 4) begin
            a = bitpos(u, 1); b = bitpos(l, 0);
            if (a < 4 && b < 4)  d = 208 + a * 4 + b;
            else if (b < 4)      d = 228 + b;
            else if (a < 4)      d = 236 + a;
            else                 d = 247;
        end else begin
            e = 1'b1;
        end
        return {e, k, 8'(d)};
    endfunction

    logic [9:0] legal[$];

    function automatic logic [9:0] rnd_sym(input int bad_pct);
        logic [9:0] s;
        logic [9:0] r;
        if (int'($urandom_range(99)) < bad_pct) begin
            do begin
                s = 10'($urandom);
                r = ref_dec(s);
            end while (!r[9]);
            return s;
        end
        return legal[$urandom_range(legal.size() - 1)];
    endfunction

    function automatic logic [19:0] beat(input int bad_pct);
        return {rnd_sym(bad_pct), rnd_sym(bad_pct)};
    endfunction

    // ---- beat-level model of the output stage, lock state and error count ----
    logic                   m_valid, m_locked;
    logic [LANES-1:0][7:0]  m_data;
    logic [LANES-1:0]       m_k, m_e;
    int                     m_run, m_cnt;

    task automatic model_reset();
        m_valid = 1'b0; m_locked = 1'b0; m_data = '0; m_k = '0; m_e = '0;
        m_run = 0; m_cnt = 0;
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        valid_i = 1'b0; ready_i = 1'b0; err_clr_i = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_data", 32'(data_o), 0);
        chk("rst_k", 32'(k_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_locked", 32'(locked_o), 0);
        chk("rst_errcnt", 32'(err_cnt_o), 0);
        @(posedge clk);
        #1 reset_n_i = 1'b1;
        model_reset();
    endtask

    task automatic step(input logic v, input logic [19:0] d, input logic rdy, input logic clr);
        logic       acc, be;
        logic [9:0] r;
        int         nerr;
        valid_i = v; data_i = d; ready_i = rdy; err_clr_i = clr;
        #2;
        chk("ready_o", 32'(ready_o), 32'(!m_valid || rdy));
        acc = v && (!m_valid || rdy);
        @(posedge clk);
        if (acc) begin
            be = 1'b0; nerr = 0;
            for (int n = 0; n < LANES; n++) begin
                r = ref_dec(d[10*n +: 10]);
                m_data[n] = r[7:0]; m_k[n] = r[8]; m_e[n] = r[9];
                be |= r[9];
                nerr += int'(r[9]);
            end
            if (!m_locked) begin
                if (be) m_run = 0;
                else begin
                    m_run++;
                    if (m_run == LOCKN) begin m_locked = 1'b1; m_run = 0; end
                end
            end else begin
                if (!be) m_run = 0;
                else begin
                    m_run++;
                    if (m_run == UNLKN) begin m_locked = 1'b0; m_run = 0; end
                end
            end
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        if (clr)      m_cnt = 0;
        else if (acc) m_cnt = (m_cnt + nerr > EMAX) ? EMAX : m_cnt + nerr;
        #1;
        chk("valid_o", 32'(valid_o), 32'(m_valid));
        chk("locked_o", 32'(locked_o), 32'(m_locked));
        chk("err_cnt_o", 32'(err_cnt_o), 32'(m_cnt));
        if (m_valid) begin
            chk("data_o", 32'(data_o), 32'(m_data));
            chk("k_o", 32'(k_o), 32'(m_k));
            chk("err_o", 32'(err_o), 32'(m_e));
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] r;
            r = ref_dec(10'(i));
            if (!r[9]) legal.push_back(10'(i));
        end
        model_reset();
        #2;
        do_reset();

        // directed decode points
        step(1'b1, {10'b11100_11000, 10'b00111_00011}, 1'b1, 1'b0);
        chk("tp_data_f300", 32'(data_o), 32'h0000_F300);
        chk("tp_k0", 32'(k_o), 0);
        step(1'b1, {10'b10100_11010, 10'b10100_11100}, 1'b1, 1'b0);
        chk("tp_kdata", 32'(data_o), 32'h0000_0001);
        chk("tp_k11", 32'(k_o), 32'h3);
        step(1'b1, {10'b11111_00000, 10'b01111_10000}, 1'b1, 1'b0);
        chk("tp_f6_err", 32'(data_o), 32'h0000_00F6);
        chk("tp_err10", 32'(err_o), 32'h2);
        chk("tp_cnt1", 32'(err_cnt_o), 1);
        step(1'b1, beat(100), 1'b1, 1'b0);
        chk("tp_cnt3", 32'(err_cnt_o), 3);

        // lock acquisition and loss
        do_reset();
        for (int i = 0; i < LOCKN - 1; i++) step(1'b1, beat(0), 1'b1, 1'b0);
        chk("lock_pre", 32'(locked_o), 0);
        step(1'b1, beat(0), 1'b1, 1'b0);
        chk("lock_acq", 32'(locked_o), 1);
        for (int i = 0; i < 3; i++) step(1'b1, beat(100), 1'b1, 1'b0);
        step(1'b1, beat(0), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, beat(100), 1'b1, 1'b0);
        chk("lock_hold", 32'(locked_o), 1);
        step(1'b1, beat(100), 1'b1, 1'b0);
        chk("lock_drop", 32'(locked_o), 0);

        // backpressure then release
        step(1'b1, beat(0), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, beat(20), 1'b0, 1'b0);
        chk("bp_ready_low", 32'(ready_o), 0);
        for (int i = 0; i < 10; i++) step(1'b1, beat(20), 1'b1, 1'b0);

        // counter saturation and clear priority
        for (int i = 0; i < 10; i++) step(1'b1, beat(100), 1'b1, 1'b0);
        chk("sat_15", 32'(err_cnt_o), 15);
        step(1'b1, beat(100), 1'b1, 1'b1);
        chk("clr_wins", 32'(err_cnt_o), 0);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(99) < 75), beat(15), 1'($urandom_range(99) < 70),
                 1'($urandom_range(99) < 3));

        // asynchronous reset mid-stream with a beat pending
        step(1'b1, beat(100), 1'b0, 1'b0);
        step(1'b1, beat(100), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, beat(10), 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
